jtag_tap: RTL and testbench
===========================

# jtag_tap

Parametrised JTAG test access port: the next generation of the JTAG stub. It adds configurable instruction width, a configurable bank of equal-width scratch data registers, and a parameter-set IDCODE. It also drives a TDO output-enable, publishes TAP status and update strobes, and exposes the scratch bank to the fabric. It sits between the chip-level JTAG pins and on-chip debug and configuration logic.

## Interface
Parameters:
- IR_WIDTH, 6, instruction register width; must satisfy 2^IR_WIDTH ≥ NUM_SCRATCH+3.
- NUM_SCRATCH, 4, number of scratch data registers (1..16).
- DR_WIDTH, 16, width of each scratch register (1..32).
- IDCODE_VAL, 32'hbeefcafe, value captured by the IDCODE instruction.

Ports:
- tck, in, 1, the single clock; all flops are on this clock.
- trst, in, 1, reset; synchronous, active-high.
- tms, in, 1, TAP mode select.
- tdi, in, 1, serial data in.
- tdo, out, 1, serial data out.
- tdo_oe, out, 1, high while shifting IR or DR.
- tap_state, out, 4, current TAP state encoding.
- ir, out, IR_WIDTH, current instruction.
- upd_dr, out, 1, one-cycle pulse after a scratch register is written.
- upd_ir, out, 1, one-cycle pulse after IR is written.
- scratch, out, NUM_SCRATCH*DR_WIDTH, scratch bank, register k at bits [k*DR_WIDTH +: DR_WIDTH].

## Operation
- **State encoding:** standard 16-state IEEE 1149.1 TAP controller.
  - RESET=0, IDLE=1, SEL_DR=2, CAP_DR=3, SHIFT_DR=4, EXIT1_DR=5, PAUSE_DR=6, EXIT2_DR=7, UPD_DR=8.
  - SEL_IR=9, CAP_IR=A, SHIFT_IR=B, EXIT1_IR=C, PAUSE_IR=D, EXIT2_IR=E, UPD_IR=F.
- **Transitions:** standard 1149.1 TMS transitions. Five consecutive tms=1 edges reach RESET from any state.
- **Instructions:**
  - 0 = NOP: 1-bit register, captures 0.
  - 1..NUM_SCRATCH = SCRATCH[k-1]: DR_WIDTH-bit register.
  - 2^IR_WIDTH−2 = IDCODE: 32-bit register.
  - all-ones = BYPASS: 1-bit register, captures 0.
  - Any other code behaves as BYPASS.
- **CAP_IR:** ir_shift loads {0…0,1}, so bit 0 = 1 and bit 1 = 0.
- **CAP_DR:** dr_shift loads 0 (NOP/BYPASS), scratch[k] (SCRATCH), or IDCODE_VAL (IDCODE).
- **SHIFT_IR:** ir_shift = {tdi, ir_shift[IR_WIDTH-1:1]}.
- **SHIFT_DR:** right shift with tdi entering at bit L−1, where L is the selected register length (1, DR_WIDTH or 32).
  - Bits ≥ L are held at 0.
- **UPD_IR:** ir ← ir_shift; upd_ir pulses.
- **UPD_DR:**
  - Under SCRATCH[k]: scratch[k] ← dr_shift[DR_WIDTH-1:0] and upd_dr pulses.
  - Under any other instruction: no register changes and no pulse.
- **RESET state (entered via TMS):** ir ← IDCODE. Scratch contents are preserved.
- **trst=1:** state ← RESET, ir ← IDCODE, scratch ← 0, shift registers ← 0, strobes ← 0, tdo ← 0, tdo_oe ← 0.
  - trst overrides tms and any in-progress shift.

## Timing
- **Posedge tck:** state, ir_shift, dr_shift, ir, scratch, upd_ir and upd_dr update.
- **Negedge tck:** tdo and tdo_oe update.
  - In SHIFT_IR: tdo ← ir_shift[0], tdo_oe ← 1.
  - In SHIFT_DR: tdo ← dr_shift[0], tdo_oe ← 1.
  - In all other states: tdo_oe ← 0 and tdo holds its value.
  - The negedge flops also clear when trst is sampled high at negedge.
- **Bit ordering:**
  - The first bit out appears on the falling edge after the CAP→SHIFT posedge, and is the LSB of the captured value.
  - The last bit is presented in SHIFT and sampled by the host at the SHIFT→EXIT1 posedge.
- **Strobe timing:**
  - upd_ir and upd_dr are high for exactly the one cycle following the posedge that leaves UPD_IR / UPD_DR.
  - ir and scratch are valid in that same cycle.
- **Pause:** PAUSE and EXIT2 preserve shift contents. Re-entering SHIFT resumes without recapture.
- **Zero-length shift:** CAP→EXIT1 directly leaves the captured value intact, and UPD writes it back, so a scratch register is unchanged.
- **tap_state:** registered; it reflects the current state with no combinational path from tms.

## Structure
- Package jtag_pkg holds:
  - the 4-bit state encodings;
  - functions returning the NOP/IDCODE/BYPASS codes for a given IR_WIDTH;
  - the default IDCODE.
- Sub-module jtag_tap_fsm: the state register plus next-state logic (tck, trst, tms → tap_state).
- The top level holds the IR, the DR mux/shift logic, the scratch bank and the TDO logic.

## Test plan
- **TMS reset:** arbitrary state, tms=1 for 5 edges → tap_state=0 and ir=6'h3e.
- **IDCODE read:** reset, then SHIFT_DR for 32 bits → tdo LSB-first gives 32'hbeefcafe; tdo_oe high only during shift.
- **IR capture and update:** shift IR=2 → first two tdo bits 1,0; upd_ir pulses once; ir=2.
- **Scratch write/readback:** shift 16'hA5C3 into SCRATCH[1] → upd_dr one cycle, scratch[31:16]=A5C3; recapture → tdo returns A5C3. Other scratch registers remain 0.
- **BYPASS and unknown code:** IR=6'h3f, then IR=6'h20; shift 8 bits of tdi pattern 10110010 → tdo equals tdi delayed by one bit.
- **Mid-shift trst:** trst high mid-SHIFT_DR of SCRATCH[0] → next cycle tap_state=0, ir=IDCODE, scratch all 0, tdo_oe=0, no upd_dr pulse.

Source files
------------

// File: rtl/jtag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_pkg : TAP state encodings, instruction-code helpers, IDCODE   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'h0,
    ST_IDLE     = 4'h1,
    ST_SEL_DR   = 4'h2,
    ST_CAP_DR   = 4'h3,
    ST_SHIFT_DR = 4'h4,
    ST_EXIT1_DR = 4'h5,
    ST_PAUSE_DR = 4'h6,
    ST_EXIT2_DR = 4'h7,
    ST_UPD_DR   = 4'h8,
    ST_SEL_IR   = 4'h9,
    ST_CAP_IR   = 4'hA,
    ST_SHIFT_IR = 4'hB,
    ST_EXIT1_IR = 4'hC,
    ST_PAUSE_IR = 4'hD,
    ST_EXIT2_IR = 4'hE,
    ST_UPD_IR   = 4'hF
  } tap_state_e;

  localparam logic [31:0] C_IDCODE_DEFAULT = 32'hbeefcafe;

  function automatic logic [31:0] ir_bypass_code(input int unsigned ir_width);
    return (32'd1 << ir_width) - 32'd1;
  endfunction

  function automatic logic [31:0] ir_idcode_code(input int unsigned ir_width);
    return ir_bypass_code(ir_width) - 32'd1;
  endfunction

  // NOP is the all-zeros code at every width.
  function automatic logic [31:0] ir_nop_code(input int unsigned ir_width);
    return ir_bypass_code(ir_width) & 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_tap_fsm : IEEE 1149.1 TAP controller state register           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e tap_state,
  output tap_state_e next_state
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_ff @(posedge tck) begin
    if (trst) state_q <= ST_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:    state_d = tms ? ST_RESET    : ST_IDLE;
      ST_IDLE:     state_d = tms ? ST_SEL_DR   : ST_IDLE;
      ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_d = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_IDLE;
      ST_SEL_IR:   state_d = tms ? ST_RESET    : ST_CAP_IR;
      ST_CAP_IR:   state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_d = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_IDLE;
      default:     state_d = ST_RESET;
    endcase
  end

  assign tap_state  = state_q;
  assign next_state = state_d;

endmodule
`default_nettype wire

// File: rtl/jtag_tap.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_tap : parametrised TAP with IR, scratch DR bank, IDCODE, TDO  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = 6,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned DR_WIDTH    = 16,
  parameter logic [31:0] IDCODE_VAL  = C_IDCODE_DEFAULT
) (
  input  logic                            tck,
  input  logic                            trst,
  input  logic                            tms,
  input  logic                            tdi,
  output logic                            tdo,
  output logic                            tdo_oe,
  output logic [3:0]                      tap_state,
  output logic [IR_WIDTH-1:0]             ir,
  output logic                            upd_dr,
  output logic                            upd_ir,
  output logic [NUM_SCRATCH*DR_WIDTH-1:0] scratch
);

  localparam logic [IR_WIDTH-1:0] C_IR_IDCODE = IR_WIDTH'(ir_idcode_code(IR_WIDTH));

  tap_state_e w_state;
  tap_state_e w_state_nxt;

  logic [IR_WIDTH-1:0]    ir_q;
  logic [IR_WIDTH-1:0]    ir_shift_q;
  logic [31:0]            dr_shift_q;
  logic                   upd_ir_q;
  logic                   upd_dr_q;
  logic                   tdo_q;
  logic                   tdo_oe_q;

  logic [NUM_SCRATCH-1:0] w_scr_sel;
  logic [31:0]            w_scr_cap;
  logic                   w_scr_hit;
  logic                   w_is_idcode;
  logic [5:0]             w_dr_len;
  logic [31:0]            w_dr_cap;
  logic [31:0]            w_dr_shift;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .tap_state  (w_state),
    .next_state (w_state_nxt)
  );

  always_comb begin
    w_scr_sel = '0;
    w_scr_cap = '0;
    for (int k = 0; k < NUM_SCRATCH; k++) begin
      if (ir_q == IR_WIDTH'(k + 1)) begin
        w_scr_sel[k] = 1'b1;
        w_scr_cap    = 32'(scratch[k*DR_WIDTH +: DR_WIDTH]);
      end
    end
  end

  assign w_scr_hit   = |w_scr_sel;
  assign w_is_idcode = (ir_q == C_IR_IDCODE);
  assign w_dr_len    = w_scr_hit ? 6'(DR_WIDTH) : (w_is_idcode ? 6'd32 : 6'd1);
  assign w_dr_cap    = w_scr_hit ? w_scr_cap : (w_is_idcode ? IDCODE_VAL : 32'd0);
  // Bits at or above the selected length stay zero, so OR-ing tdi into bit L-1 suffices.
  assign w_dr_shift  = (dr_shift_q >> 1) | (32'(tdi) << (w_dr_len - 6'd1));

  always_ff @(posedge tck) begin
    if (trst) begin
      ir_q       <= C_IR_IDCODE;
      ir_shift_q <= '0;
      dr_shift_q <= '0;
      upd_ir_q   <= 1'b0;
      upd_dr_q   <= 1'b0;
    end else begin
      upd_ir_q <= 1'b0;
      upd_dr_q <= 1'b0;
      case (w_state)
        ST_CAP_IR:   ir_shift_q <= IR_WIDTH'(1);
        ST_SHIFT_IR: ir_shift_q <= {tdi, ir_shift_q[IR_WIDTH-1:1]};
        ST_UPD_IR: begin
          ir_q     <= ir_shift_q;
          upd_ir_q <= 1'b1;
        end
        ST_CAP_DR:   dr_shift_q <= w_dr_cap;
        ST_SHIFT_DR: dr_shift_q <= w_dr_shift;
        ST_UPD_DR:   upd_dr_q   <= w_scr_hit;
        default: ;
      endcase
      if (w_state_nxt == ST_RESET) ir_q <= C_IR_IDCODE;
    end
  end

  for (genvar k = 0; k < NUM_SCRATCH; k++) begin : g_scratch
    logic [DR_WIDTH-1:0] scr_q;
    always_ff @(posedge tck) begin
      if (trst)                                        scr_q <= '0;
      else if (w_state == ST_UPD_DR && w_scr_sel[k]) scr_q <= dr_shift_q[DR_WIDTH-1:0];
    end
    assign scratch[k*DR_WIDTH +: DR_WIDTH] = scr_q;
  end

  // Falling-edge launch gives the host a full half cycle of setup before it samples.
  always_ff @(negedge tck) begin
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_oe_q <= 1'b0;
      if (w_state == ST_SHIFT_IR) begin
        tdo_q    <= ir_shift_q[0];
        tdo_oe_q <= 1'b1;
      end else if (w_state == ST_SHIFT_DR) begin
        tdo_q    <= dr_shift_q[0];
        tdo_oe_q <= 1'b1;
      end
    end
  end

  assign tdo       = tdo_q;
  assign tdo_oe    = tdo_oe_q;
  assign tap_state = w_state;
  assign ir        = ir_q;
  assign upd_ir    = upd_ir_q;
  assign upd_dr    = upd_dr_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtag_tap : host-level scans against a behavioural TAP model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_jtag_tap;

  localparam int          IRW = 6;
  localparam int          NS  = 4;
  localparam int          DRW = 16;
  localparam logic [31:0] IDC = 32'hbeefcafe;

  logic tck  = 1'b0;
  logic trst = 1'b1;
  logic tms  = 1'b1;
  logic tdi  = 1'b0;
  logic tdo, tdo_oe, upd_dr, upd_ir;
  logic [3:0]        tap_state;
  logic [IRW-1:0]    ir;
  logic [NS*DRW-1:0] scratch;

  jtag_tap #(
    .IR_WIDTH    (IRW),
    .NUM_SCRATCH (NS),
    .DR_WIDTH    (DRW),
    .IDCODE_VAL  (IDC)
  ) dut (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_oe    (tdo_oe),
    .tap_state (tap_state),
    .ir        (ir),
    .upd_dr    (upd_dr),
    .upd_ir    (upd_ir),
    .scratch   (scratch)
  );

  always #5 tck = ~tck;

  // IEEE 1149.1 transition table, indexed by state, for tms=0 and tms=1.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int             m_state   = 0;
  logic [IRW-1:0] m_ir      = 6'h3e;
  logic [IRW-1:0] m_ir_pend = '0;
  logic [31:0]    m_dr_pend = '0;
  logic [DRW-1:0] m_scr[NS] = '{default: '0};
  logic           trst_next = 1'b1;

  function automatic bit scr_sel(input logic [IRW-1:0] code);
    return (code >= 1) && (code <= NS);
  endfunction

  function automatic logic [63:0] scr_packed();
    logic [63:0] v = '0;
    for (int k = 0; k < NS; k++) v[k*DRW +: DRW] = m_scr[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: sample tdo as the host would, drive inputs, then advance the model.
  task automatic tick(input logic t_tms, input logic t_tdi, output logic t_tdo);
    int  old;
    bit  exp_ui, exp_ud;
    @(negedge tck); #1;
    t_tdo = tdo;
    chk("tdo_oe", 64'(tdo_oe), 64'(m_state == 4 || m_state == 11));
    tms  = t_tms;
    tdi  = t_tdi;
    trst = trst_next;
    @(posedge tck); #1;
    old    = m_state;
    exp_ui = 1'b0;
    exp_ud = 1'b0;
    if (trst) begin
      m_state = 0;
      m_ir    = 6'h3e;
      m_scr   = '{default: '0};
    end else begin
      m_state = t_tms ? nxt1[old] : nxt0[old];
      exp_ui  = (old == 15);
      exp_ud  = (old == 8) && scr_sel(m_ir);
      if (old == 15) m_ir = m_ir_pend;
      if (exp_ud) m_scr[m_ir - 1] = m_dr_pend[DRW-1:0];
      if (m_state == 0) m_ir = 6'h3e;
    end
    chk("tap_state", 64'(tap_state), 64'(m_state));
    chk("upd_ir", 64'(upd_ir), 64'(exp_ui));
    chk("upd_dr", 64'(upd_dr), 64'(exp_ud));
  endtask

  // Full IR or DR scan from IDLE back to IDLE, optional pause after bit pause_at-1.
  task automatic scan(input bit is_ir, input logic [63:0] din, input int n,
                      input int pause_at, output logic [63:0] dout);
    int          L;
    logic [63:0] cap, mask, dn, fin, exp;
    logic        o;
    bit          last, pz;
    if (is_ir)                 begin L = IRW; cap = 64'd1; end
    else if (scr_sel(m_ir))    begin L = DRW; cap = 64'(m_scr[m_ir - 1]); end
    else if (m_ir == 6'h3e)    begin L = 32;  cap = 64'(IDC); end
    else                       begin L = 1;   cap = 64'd0; end
    mask = (64'd1 << L) - 64'd1;
    dn   = din & ((64'd1 << n) - 64'd1);
    exp  = '0;
    for (int i = 0; i < n; i++) exp[i] = (i < L) ? cap[i] : dn[i - L];
    fin  = (n >= L) ? ((dn >> (n - L)) & mask) : (((cap >> n) | (dn << (L - n))) & mask);
    if (is_ir) m_ir_pend = fin[IRW-1:0];
    else       m_dr_pend = fin[31:0];
    dout = '0;
    tick(1'b1, 1'b0, o);
    if (is_ir) tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(n == 0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      pz   = (pause_at != 0) && (i == pause_at - 1) && !last;
      tick(last || pz, din[i], o);
      dout[i] = o;
      if (pz) begin
        tick(1'b0, 1'b0, o);
        tick(1'b0, 1'b0, o);
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
      end
    end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    if (n > 0) chk(is_ir ? "ir_tdo" : "dr_tdo", dout, exp);
    chk("ir", 64'(ir), 64'(m_ir));
    chk("scratch", 64'(scratch), scr_packed());
  endtask

  logic [7:0]  pbits[4] = '{8'h09, 8'h03, 8'h53, 8'h01};
  int          plen[4]  = '{5, 4, 7, 2};
  logic [63:0] d;
  logic        o;
  int          p, r, n;
  logic [5:0]  code;

  initial begin
    // Reset state
    tick(1'b1, 1'b0, o);
    tick(1'b1, 1'b0, o);
    chk("rst_tdo", 64'(o), 64'd0);
    chk("rst_ir", 64'(ir), 64'h3e);
    chk("rst_scratch", 64'(scratch), 64'd0);
    trst_next = 1'b0;
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);

    // IDCODE read
    scan(1'b0, {$urandom, $urandom}, 32, 0, d);
    chk("idcode", d[31:0], 64'hbeefcafe);

    // IR capture and update
    scan(1'b1, 64'd2, IRW, 0, d);
    chk("ir_cap_bits", 64'(d[1:0]), 64'd1);
    chk("ir_is_2", 64'(ir), 64'd2);

    // Scratch write / readback / zero-length / paused readback
    scan(1'b0, 64'ha5c3, DRW, 0, d);
    chk("scr1_write", 64'(scratch[31:16]), 64'ha5c3);
    chk("scr_others", {32'd0, scratch[63:32]} | 64'(scratch[15:0]), 64'd0);
    scan(1'b0, 64'(32'($urandom)), 0, 0, d);
    chk("scr1_zero_len", 64'(scratch[31:16]), 64'ha5c3);
    scan(1'b0, 64'ha5c3, DRW, 5, d);
    chk("scr1_readback", 64'(d[15:0]), 64'ha5c3);

    // BYPASS and unknown code
    scan(1'b1, 64'h3f, IRW, 0, d);
    scan(1'b0, 64'hb2, 8, 0, d);
    chk("bypass_3f", 64'(d[7:0]), 64'h64);
    scan(1'b1, 64'h20, IRW, 0, d);
    scan(1'b0, 64'hb2, 8, 3, d);
    chk("bypass_20", 64'(d[7:0]), 64'h64);

    // TMS reset from assorted states (under BYPASS so no scratch writes occur)
    for (int it = 0; it < 4; it++) begin
      scan(1'b1, 64'h3f, IRW, 0, d);
      p = it;
      for (int b = 0; b < plen[p]; b++) tick(pbits[p][b], 1'($urandom), o);
      repeat (5) tick(1'b1, 1'($urandom), o);
      chk("tms_reset_state", 64'(tap_state), 64'd0);
      chk("tms_reset_ir", 64'(ir), 64'h3e);
      tick(1'b0, 1'b0, o);
    end

    // Randomized scans
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 7);
      if (r < 4)       code = 6'(r + 1);
      else if (r == 4) code = 6'h00;
      else if (r == 5) code = 6'h3e;
      else if (r == 6) code = 6'h3f;
      else             code = 6'($urandom);
      if ($urandom_range(0, 9) < 8) scan(1'b1, 64'(code), IRW, $urandom_range(0, 4), d);
      else                          scan(1'b1, {$urandom, $urandom}, $urandom_range(0, 9), 0, d);
      n = $urandom_range(0, 40);
      scan(1'b0, {$urandom, $urandom}, n, $urandom_range(0, 6), d);
    end

    // Mid-shift trst under SCRATCH[0]
    scan(1'b1, 64'd1, IRW, 0, d);
    scan(1'b0, 64'(32'($urandom) | 32'h20), DRW, 0, d);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    repeat (5) tick(1'b0, 1'($urandom), o);
    trst_next = 1'b1;
    tick(1'b0, 1'b0, o);
    chk("trst_state", 64'(tap_state), 64'd0);
    chk("trst_ir", 64'(ir), 64'h3e);
    chk("trst_scratch", 64'(scratch), 64'd0);
    chk("trst_upd_dr", 64'(upd_dr), 64'd0);
    tick(1'b0, 1'b0, o);
    chk("trst_tdo", 64'(o), 64'd0);
    trst_next = 1'b0;
    tick(1'b0, 1'b0, o);
    scan(1'b0, 64'd0, 32, 0, d);
    chk("idcode_after_trst", d[31:0], 64'hbeefcafe);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
